twpm_ram_arbiter: RTL

Single-clock arbiter for the 512x32 TPM command/response buffer RAM. It shares the RAM between the M4 Wishbone slave path and the LPC-side TPM register file (data provider) and replaces the LCLK/WB_CLK clock multiplexing. The RAM is clocked only by WB_CLK. Data-provider byte accesses cross from LCLK through a toggle handshake, and each granted access produces exactly one RAM cycle.

---
 rtl/twpm_ram_arbiter.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/twpm_ram_arbiter.sv
//------------------------------------------------------------------------------
// twpm_ram_arbiter
//
// Purpose:
//   Single-clock arbiter for the 512x32 TPM command/response buffer RAM.
//   The RAM is shared between the M4 Wishbone slave path and the LPC-side
//   TPM register file (data provider, DP). All RAM controls are registered
//   in the WB_CLK domain. DP byte accesses arrive from LCLK through a
//   toggle handshake: dp_req_tgl is synchronized here, and dp_ack_tgl is
//   flipped once the access is complete. Every granted access produces
//   exactly one RAM cycle.
//
// Ports:
//   WB_CLK, WB_RST     clock (also the RAM clock), async active-high reset
//   wb_req/wb_we/wb_addr/wb_wdat/wb_be
//                      Wishbone RAM-window request (word address)
//   wb_rdat/wb_ack     read data and one-cycle acknowledge
//   exec               M4 owns the buffer (command executing)
//   dp_req_tgl/dp_we/dp_addr/dp_wdat
//                      LCLK-domain byte request (byte address)
//   dp_rdat/dp_ack_tgl registered read byte and completion toggle
//   ram_a/ram_wd/ram_wen
//                      registered RAM address, write data, byte enables
//   ram_rd             RAM read data, valid the cycle after ram_a is sampled
//   dp_drop_cnt        saturating count of dropped DP accesses
//
// Configuration:
//   TWPM_RAM_ARB_OWNER_LOCK_EN  when defined, DP accesses pending while
//   exec=1 are dropped without touching the RAM (dp_rdat=8'hFF) and counted
//   in dp_drop_cnt. When undefined, exec is ignored and dp_drop_cnt is 0.
//------------------------------------------------------------------------------
module twpm_ram_arbiter #(
    parameter int ADDR_WIDTH     = 11,
    parameter int DP_SYNC_STAGES = 2
) (
    input  logic                  WB_CLK,
    input  logic                  WB_RST,
    input  logic                  wb_req,
    input  logic                  wb_we,
    input  logic [ADDR_WIDTH-3:0] wb_addr,
    input  logic [31:0]           wb_wdat,
    input  logic [3:0]            wb_be,
    output logic [31:0]           wb_rdat,
    output logic                  wb_ack,
    input  logic                  exec,
    input  logic                  dp_req_tgl,
    input  logic                  dp_we,
    input  logic [ADDR_WIDTH-1:0] dp_addr,
    input  logic [7:0]            dp_wdat,
    output logic [7:0]            dp_rdat,
    output logic                  dp_ack_tgl,
    output logic [ADDR_WIDTH-3:0] ram_a,
    output logic [31:0]           ram_wd,
    output logic [3:0]            ram_wen,
    input  logic [31:0]           ram_rd,
    output logic [7:0]            dp_drop_cnt
);

    typedef enum logic [2:0] {
        IDLE,
        WB_ACC,
        WB_DONE,
        DP_ACC,
        DP_DONE,
        DP_DROP
    } state_t;

    state_t                    state;
    state_t                    state_next;
    logic [DP_SYNC_STAGES-1:0] dp_sync;
    logic                      dp_pend;
    logic                      last_grant_dp;
    logic [1:0]                dp_lane;
    logic                      grant_wb;
    logic                      grant_dp;
    logic                      grant_drop;

    // A DP request is outstanding whenever the synchronized request toggle
    // disagrees with our own ack toggle; flipping the ack retires it.
    assign dp_pend = dp_sync[DP_SYNC_STAGES-1] != dp_ack_tgl;

    // State register for the access sequencer.
    always_ff @(posedge WB_CLK or posedge WB_RST) begin
        if (WB_RST) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Bring the LCLK request toggle into WB_CLK through a plain flop chain.
    // Only the toggle crosses; dp_we/dp_addr/dp_wdat are held stable by the
    // LCLK side until the ack toggle comes back, so they are sampled directly.
    always_ff @(posedge WB_CLK or posedge WB_RST) begin
        if (WB_RST) begin
            dp_sync <= '0;
        end else begin
            dp_sync <= {dp_sync[DP_SYNC_STAGES-2:0], dp_req_tgl};
        end
    end

    // Arbitration and sequencing. In IDLE a lone requester is granted at
    // once; on a tie the side that was not granted last wins. With the
    // owner lock enabled, a DP request seen while the M4 owns the buffer is
    // diverted to the short drop path instead of the RAM. The Wishbone ack
    // and read data are decoded straight from the DONE state so the RAM
    // output is returned in the same cycle it becomes valid.
    always_comb begin
        state_next = state;
        grant_wb   = 1'b0;
        grant_dp   = 1'b0;
        grant_drop = 1'b0;
        wb_ack     = 1'b0;
        wb_rdat    = 32'h0000_0000;

        case (state)
            IDLE: begin
                if (wb_req && (!dp_pend || last_grant_dp)) begin
                    grant_wb   = 1'b1;
                    state_next = WB_ACC;
                end else if (dp_pend) begin
`ifdef TWPM_RAM_ARB_OWNER_LOCK_EN
                    if (exec) begin
                        grant_drop = 1'b1;
                        state_next = DP_DROP;
                    end else begin
                        grant_dp   = 1'b1;
                        state_next = DP_ACC;
                    end
`else
                    grant_dp   = 1'b1;
                    state_next = DP_ACC;
`endif
                end
            end
            WB_ACC:  state_next = WB_DONE;
            WB_DONE: begin
                wb_ack     = 1'b1;
                wb_rdat    = ram_rd;
                state_next = IDLE;
            end
            DP_ACC:  state_next = DP_DONE;
            DP_DONE: state_next = IDLE;
            DP_DROP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // RAM control registers. They are loaded on a grant and the write
    // enables are cleared on every other cycle, so a write strobes the RAM
    // for exactly one edge. Address and data simply hold afterwards. The DP
    // byte is replicated on all lanes and steered by its one-hot enable.
    always_ff @(posedge WB_CLK or posedge WB_RST) begin
        if (WB_RST) begin
            ram_a   <= '0;
            ram_wd  <= 32'h0000_0000;
            ram_wen <= 4'b0000;
        end else if (grant_wb) begin
            ram_a   <= wb_addr;
            ram_wd  <= wb_wdat;
            ram_wen <= wb_we ? wb_be : 4'b0000;
        end else if (grant_dp) begin
            ram_a   <= dp_addr[ADDR_WIDTH-1:2];
            ram_wd  <= {4{dp_wdat}};
            ram_wen <= dp_we ? (4'b0001 << dp_addr[1:0]) : 4'b0000;
        end else begin
            ram_wen <= 4'b0000;
        end
    end

    // Round-robin memory and the byte lane of the DP access in flight. The
    // lane is captured at grant so the read byte is selected from a value
    // owned by this clock domain. A dropped DP access still counts as a DP
    // grant for fairness.
    always_ff @(posedge WB_CLK or posedge WB_RST) begin
        if (WB_RST) begin
            last_grant_dp <= 1'b1;
            dp_lane       <= 2'b00;
        end else if (grant_wb) begin
            last_grant_dp <= 1'b0;
        end else if (grant_dp || grant_drop) begin
            last_grant_dp <= 1'b1;
            dp_lane       <= dp_addr[1:0];
        end
    end

    // DP completion: capture the addressed byte (or 8'hFF for a dropped
    // access) and flip the ack toggle in the same edge, so the LCLK side
    // sees valid data as soon as it sees the toggle.
    always_ff @(posedge WB_CLK or posedge WB_RST) begin
        if (WB_RST) begin
            dp_rdat    <= 8'h00;
            dp_ack_tgl <= 1'b0;
        end else if (state == DP_DONE) begin
            dp_rdat    <= ram_rd[{dp_lane, 3'b000} +: 8];
            dp_ack_tgl <= ~dp_ack_tgl;
        end
`ifdef TWPM_RAM_ARB_OWNER_LOCK_EN
        else if (state == DP_DROP) begin
            dp_rdat    <= 8'hFF;
            dp_ack_tgl <= ~dp_ack_tgl;
        end
`endif
    end

`ifdef TWPM_RAM_ARB_OWNER_LOCK_EN
    // Count dropped DP accesses, sticking at 255 rather than wrapping.
    always_ff @(posedge WB_CLK or posedge WB_RST) begin
        if (WB_RST) begin
            dp_drop_cnt <= 8'h00;
        end else if (state == DP_DROP && dp_drop_cnt != 8'hFF) begin
            dp_drop_cnt <= dp_drop_cnt + 8'h01;
        end
    end
`else
    logic unused_exec;

    assign unused_exec = exec;
    assign dp_drop_cnt = 8'h00;
`endif

endmodule
